ofmap_writer: RTL and testbench

Drains quantized output-feature-map rows produced by the MMU accumulator and writes them into the global buffer (GLB) as one packed word per row. It sits between the accumulator output (`ofmap_row`/`ofmap_valid`, no backpressure available) and the GLB write port (valid/ready), absorbing GLB stalls in a small row FIFO. It generates sequential write addresses from a per-tile base and signals completion after a fixed row count.

---
 rtl/ofmap_writer.sv | 116 +++++++++++
 tb/tb_ofmap_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writer.sv
// ofmap_writer: byte-reverses accumulator rows into a small FIFO and writes them to the GLB at sequential addresses.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          one-cycle tile start (honoured in IDLE only), latches base_addr_i
//   base_addr_i      first GLB word address of the tile
//   ofmap_row_i      accumulator row, column 0 in the MS byte
//   ofmap_valid_i    row strobe, no backpressure
//   glb_wr_en_o      GLB write valid (FIFO not empty)
//   glb_wr_ready_i   GLB accepts the write
//   glb_wr_addr_o    write address, +1 per accepted write, wraps
//   glb_wr_data_o    FIFO head, column 0 in the LS byte
//   busy_o           high while a tile is running or draining
//   done_o           one-cycle pulse once every row of the tile is written
//   overflow_o       sticky flag: a row arrived while the FIFO was full
//
// Build option: define OFMAP_WRITER_RELU_EN to clamp negative (signed) bytes to zero before the FIFO.
module ofmap_writer #(
   parameter int PE_SIZE     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int BUF_DEPTH   = 8,
   parameter int OUT_ROW_NUM = 294
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic [ADDR_WIDTH-1:0]         base_addr_i,
   input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
   input  logic                          ofmap_valid_i,
   output logic                          glb_wr_en_o,
   input  logic                          glb_wr_ready_i,
   output logic [ADDR_WIDTH-1:0]         glb_wr_addr_o,
   output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wr_data_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          overflow_o
);
   localparam int ROW_W = DATA_WIDTH * PE_SIZE;
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(OUT_ROW_NUM + 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [ROW_W-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0] fill;
   logic [CNT_W-1:0] row_cnt;
   logic [ROW_W-1:0] row_fmt;
   logic row_in, full, empty, pop, push, drop, last_row;

   for (genvar k = 0; k < PE_SIZE; k++) begin : g_col
      logic [DATA_WIDTH-1:0] b;
      assign b = ofmap_row_i[(PE_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
`ifdef OFMAP_WRITER_RELU_EN
      assign row_fmt[k*DATA_WIDTH +: DATA_WIDTH] = b[DATA_WIDTH-1] ? '0 : b;
`else
      assign row_fmt[k*DATA_WIDTH +: DATA_WIDTH] = b;
`endif
   end

   assign row_in        = (state == RUN) && ofmap_valid_i;
   assign empty         = fill == '0;
   assign full          = fill == (PTR_W+1)'(BUF_DEPTH);
   assign pop           = !empty && glb_wr_ready_i;
   // a full FIFO still takes a row when the head leaves in the same cycle
   assign push          = row_in && (!full || pop);
   assign drop          = row_in && full && !pop;
   assign last_row      = row_in && (row_cnt == CNT_W'(OUT_ROW_NUM - 1));
   assign glb_wr_en_o   = !empty;
   assign glb_wr_data_o = empty ? '0 : mem[rd_ptr];

   always_comb begin
      state_nxt = state;
      busy_o    = (state == RUN) || (state == DRAIN);
      done_o    = state == DONE;
      case (state)
         IDLE:    state_nxt = start_i ? RUN : IDLE;
         RUN:     state_nxt = last_row ? DRAIN : RUN;
         // leave as soon as the final write is accepted so done_o follows it by one cycle
         DRAIN:   state_nxt = (empty || (fill == (PTR_W+1)'(1) && pop)) ? DONE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fill          <= '0;
         row_cnt       <= '0;
         glb_wr_addr_o <= '0;
         overflow_o    <= 1'b0;
      end else begin
         state  <= state_nxt;
         wr_ptr <= wr_ptr + PTR_W'(push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         fill   <= fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         if (row_in)
            row_cnt <= row_cnt + CNT_W'(1);
         if (state == IDLE && start_i) begin
            row_cnt       <= '0;
            overflow_o    <= 1'b0;
            glb_wr_addr_o <= base_addr_i;
         end else begin
            if (pop)
               glb_wr_addr_o <= glb_wr_addr_o + ADDR_WIDTH'(1);
            if (drop)
               overflow_o <= 1'b1;
         end
      end

   always_ff @(posedge clk)
      if (push)
         mem[wr_ptr] <= row_fmt;
endmodule

// File: tb/tb_ofmap_writer.sv
// tb_ofmap_writer: scoreboard bench for ofmap_writer with a queue-based reference model.
module tb_ofmap_writer;
   localparam int N     = 9;
   localparam int DEPTH = 8;
   logic        clk, rst_n, start_i, ofmap_valid_i, glb_wr_ready_i;
   logic [15:0] base_addr_i, glb_wr_addr_o;
   logic [31:0] ofmap_row_i, glb_wr_data_o;
   logic        glb_wr_en_o, busy_o, done_o, overflow_o;

   ofmap_writer #(.PE_SIZE(4), .DATA_WIDTH(8), .ADDR_WIDTH(16), .BUF_DEPTH(DEPTH), .OUT_ROW_NUM(N)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
      .ofmap_row_i(ofmap_row_i), .ofmap_valid_i(ofmap_valid_i), .glb_wr_en_o(glb_wr_en_o),
      .glb_wr_ready_i(glb_wr_ready_i), .glb_wr_addr_o(glb_wr_addr_o), .glb_wr_data_o(glb_wr_data_o),
      .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {logic [15:0] a; logic [31:0] d;} wr_t;
   wr_t exp_q[$];
   int n_chk = 0, n_fail = 0, n_writes = 0, n_done = 0;
   int phase = 0, occ = 0, rows = 0, cur_occ = 0;
   logic [15:0] waddr = 0;
   bit ovf = 0, mon_on = 0;
   bit nxt_busy = 0, nxt_done = 0, nxt_ovf = 0, cur_busy = 0, cur_done = 0, cur_ovf = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // expected GLB word: column k of the row lands in byte k, optionally clamped
   function automatic logic [31:0] fmt(input logic [31:0] r);
      logic [31:0] o;
      logic [7:0] b;
      o = '0;
      for (int k = 0; k < 4; k++) begin
         b = r[(3-k)*8 +: 8];
`ifdef OFMAP_WRITER_RELU_EN
         if (b[7]) b = 8'h00;
`endif
         o[k*8 +: 8] = b;
      end
      return o;
   endfunction

   // one clock: publish last cycle's expectations, drive new inputs, advance the model
   task automatic step(input bit st, input logic [15:0] base, input bit v, input logic [31:0] row, input bit rdy);
      bit pop;
      @(posedge clk);
      cur_busy = nxt_busy; cur_done = nxt_done; cur_ovf = nxt_ovf; cur_occ = occ;
      #1;
      start_i = st; base_addr_i = base; ofmap_valid_i = v; ofmap_row_i = row; glb_wr_ready_i = rdy;
      pop = occ > 0 && rdy;
      if (phase == 1 && v) begin
         rows++;
         if (occ < DEPTH || pop) begin
            exp_q.push_back('{waddr, fmt(row)});
            waddr++;
            occ++;
         end else ovf = 1;
      end
      if (pop) occ--;
      if (phase == 0 && st) begin
         phase = 1; rows = 0; ovf = 0; waddr = base;
      end else if (phase == 1 && rows == N) phase = 2;
      else if (phase == 2 && occ == 0) phase = 3;
      else if (phase == 3) phase = 0;
      nxt_busy = phase == 1 || phase == 2;
      nxt_done = phase == 3;
      nxt_ovf  = ovf;
   endtask

   task automatic wait_idle(input int done_before);
      for (int i = 0; i < 200 && phase != 0; i++) step(0, 0, 0, 0, 1);
      if (phase != 0) chk("drain_timeout", 1, 0);
      step(0, 0, 0, 0, 1);
      chk("done_pulses", n_done - done_before, 1);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   always @(negedge clk) if (rst_n && mon_on) begin
      chk("wr_en", glb_wr_en_o, cur_occ > 0);
      chk("busy", busy_o, cur_busy);
      chk("done", done_o, cur_done);
      chk("overflow", overflow_o, cur_ovf);
      if (glb_wr_en_o) begin
         if (exp_q.size() == 0) chk("unexpected_write", glb_wr_addr_o, 0);
         else begin
            chk("wr_addr", glb_wr_addr_o, exp_q[0].a);
            chk("wr_data", glb_wr_data_o, exp_q[0].d);
            if (glb_wr_ready_i) begin
               void'(exp_q.pop_front());
               n_writes++;
            end
         end
      end
      if (done_o) n_done++;
   end

   task automatic chk_zero_outputs();
      chk("rst_wr_en", glb_wr_en_o, 0);
      chk("rst_wr_addr", glb_wr_addr_o, 0);
      chk("rst_wr_data", glb_wr_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_overflow", overflow_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, w;
      logic [31:0] r;
      rst_n = 1; start_i = 0; base_addr_i = 0; ofmap_row_i = 0; ofmap_valid_i = 0; glb_wr_ready_i = 0;
      #1 rst_n = 0;
      #1 chk_zero_outputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      mon_on = 1;
      // basic tile, ready high, consecutive rows
      d = n_done;
      step(1, 16'h0100, 0, 0, 1);
      for (int i = 0; i < N; i++) step(0, 0, 1, 32'h01020304 + 32'h04040404 * i, 1);
      wait_idle(d);
      // backpressure: 5 stalled cycles while 4 rows arrive
      d = n_done;
      step(1, 16'h0200, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom, 0);
      step(0, 0, 0, 0, 0);
      for (int i = 4; i < N; i++) step(0, 0, 1, $urandom, 1);
      wait_idle(d);
      // overflow: 9 rows into an 8-deep FIFO with ready low
      d = n_done; w = n_writes;
      step(1, 16'h0300, 0, 0, 0);
      for (int i = 0; i < N; i++) step(0, 0, 1, $urandom, 0);
      step(0, 0, 0, 0, 0);
      wait_idle(d);
      chk("overflow_writes", n_writes - w, DEPTH);
      // full FIFO with push and pop in the same cycle
      d = n_done; w = n_writes;
      step(1, 16'h0400, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, $urandom, 0);
      step(0, 0, 1, $urandom, 1);
      wait_idle(d);
      chk("fullpush_writes", n_writes - w, N);
      // address wrap, start mid-RUN ignored, signed-byte row
      d = n_done;
      step(1, 16'hFFFE, 0, 0, 1);
      step(0, 0, 1, 32'h80FF7F01, 1);
      step(1, 16'h1234, 1, $urandom, 1);
      for (int i = 2; i < N; i++) step(0, 0, 1, $urandom, $urandom_range(0, 3) != 0);
      wait_idle(d);
      // random tiles: gaps, random ready, random base
      for (int t = 0; t < 4; t++) begin
         d = n_done;
         step(1, 16'($urandom), 0, 0, $urandom_range(0, 1));
         for (int i = 0; i < N; ) begin
            r = $urandom;
            if ($urandom_range(0, 9) < 7) begin
               step(0, 0, 1, r, $urandom_range(0, 9) < 6);
               i++;
            end else step(0, 0, 0, r, $urandom_range(0, 9) < 6);
         end
         wait_idle(d);
      end
      // reset while stalled in DRAIN
      step(1, 16'h0500, 0, 0, 0);
      for (int i = 0; i < N; i++) step(0, 0, 1, $urandom, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      @(negedge clk);
      #2 rst_n = 0;
      #1 chk_zero_outputs();
      start_i = 0; ofmap_valid_i = 0; glb_wr_ready_i = 0;
      exp_q.delete();
      phase = 0; occ = 0; ovf = 0; rows = 0;
      nxt_busy = 0; nxt_done = 0; nxt_ovf = 0; cur_busy = 0; cur_done = 0; cur_ovf = 0; cur_occ = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      // tile after reset
      d = n_done;
      step(1, 16'h0600, 0, 0, 1);
      for (int i = 0; i < N; i++) step(0, 0, 1, $urandom, 1);
      wait_idle(d);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
